// File: rtl/hms_time_counter.sv
// BCD hours:minutes:seconds time-of-day counter with an internal seconds prescaler,
// a RUN / SET_MIN / SET_HOUR adjust machine and a one-cycle midnight pulse.
module hms_time_counter #(
    parameter int TICK_DIV = 100_000_000,
    parameter int HOUR_MOD = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       up,
    input  logic       down,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic [1:0] mode,
    output logic       day_carry
);

    localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0]     SM_MAX  = 8'h59;
    localparam logic [7:0]     HR_MAX  = {4'((HOUR_MOD - 1) / 10), 4'((HOUR_MOD - 1) % 10)};

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_MIN  = 2'b01,
        ST_SET_HOUR = 2'b10
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [3:0]    r_sec_lo, r_sec_hi, r_min_lo, r_min_hi, r_hr_lo, r_hr_hi;
    logic          r_day_carry;

    state_t        w_state;
    logic [PW-1:0] w_pre;
    logic [3:0]    w_sec_lo, w_sec_hi, w_min_lo, w_min_hi, w_hr_lo, w_hr_hi;
    logic          w_day_carry;
    logic          w_tick;
    logic          w_inc;
    logic          w_dec;

    // BCD pair step with wrap at vmax (up) or to vmax from 00 (down).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        if (v == vmax)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        if (v == 8'h00)
            return vmax;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign w_tick = (r_state == ST_RUN) && (r_pre == PRE_MAX);
    assign w_inc  = up & ~down;
    assign w_dec  = down & ~up;

    always_comb begin
        w_state     = r_state;
        w_pre       = '0;
        w_sec_lo    = r_sec_lo;
        w_sec_hi    = r_sec_hi;
        w_min_lo    = r_min_lo;
        w_min_hi    = r_min_hi;
        w_hr_lo     = r_hr_lo;
        w_hr_hi     = r_hr_hi;
        w_day_carry = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_pre = w_tick ? '0 : r_pre + PW'(1);
                // Whole carry chain resolves in the tick cycle.
                if (w_tick) begin
                    {w_sec_hi, w_sec_lo} = bcd_inc({r_sec_hi, r_sec_lo}, SM_MAX);
                    if ({r_sec_hi, r_sec_lo} == SM_MAX) begin
                        {w_min_hi, w_min_lo} = bcd_inc({r_min_hi, r_min_lo}, SM_MAX);
                        if ({r_min_hi, r_min_lo} == SM_MAX) begin
                            {w_hr_hi, w_hr_lo} = bcd_inc({r_hr_hi, r_hr_lo}, HR_MAX);
                            w_day_carry = ({r_hr_hi, r_hr_lo} == HR_MAX);
                        end
                    end
                end
                if (mode_btn) begin
                    w_state  = ST_SET_MIN;
                    w_pre    = '0;
                    w_sec_lo = 4'd0;
                    w_sec_hi = 4'd0;
                end
            end
            ST_SET_MIN: begin
                if (w_inc)
                    {w_min_hi, w_min_lo} = bcd_inc({r_min_hi, r_min_lo}, SM_MAX);
                else if (w_dec)
                    {w_min_hi, w_min_lo} = bcd_dec({r_min_hi, r_min_lo}, SM_MAX);
                if (mode_btn)
                    w_state = ST_SET_HOUR;
            end
            ST_SET_HOUR: begin
                if (w_inc)
                    {w_hr_hi, w_hr_lo} = bcd_inc({r_hr_hi, r_hr_lo}, HR_MAX);
                else if (w_dec)
                    {w_hr_hi, w_hr_lo} = bcd_dec({r_hr_hi, r_hr_lo}, HR_MAX);
                if (mode_btn)
                    w_state = ST_RUN;
            end
            default: begin
                w_state = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_pre       <= '0;
            r_sec_lo    <= 4'd0;
            r_sec_hi    <= 4'd0;
            r_min_lo    <= 4'd0;
            r_min_hi    <= 4'd0;
            r_hr_lo     <= 4'd0;
            r_hr_hi     <= 4'd0;
            r_day_carry <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pre       <= w_pre;
            r_sec_lo    <= w_sec_lo;
            r_sec_hi    <= w_sec_hi;
            r_min_lo    <= w_min_lo;
            r_min_hi    <= w_min_hi;
            r_hr_lo     <= w_hr_lo;
            r_hr_hi     <= w_hr_hi;
            r_day_carry <= w_day_carry;
        end
    end

    assign sec_lo    = r_sec_lo;
    assign sec_hi    = r_sec_hi;
    assign min_lo    = r_min_lo;
    assign min_hi    = r_min_hi;
    assign hr_lo     = r_hr_lo;
    assign hr_hi     = r_hr_hi;
    assign mode      = r_state;
    assign day_carry = r_day_carry;

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: a 24-hour and a 12-hour instance share stimulus and are
// checked each cycle against an integer time-of-day model, plus vector table and corner sequences.
module tb_hms_time_counter;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mode_btn = 1'b0;
    logic up = 1'b0;
    logic down = 1'b0;

    logic [3:0] a_sl, a_sh, a_ml, a_mh, a_hl, a_hh;
    logic [1:0] a_mode;
    logic       a_day;
    logic [3:0] b_sl, b_sh, b_ml, b_mh, b_hl, b_hh;
    logic [1:0] b_mode;
    logic       b_day;

    logic [26:0] act24, act12;
    assign act24 = {a_hh, a_hl, a_mh, a_ml, a_sh, a_sl, a_mode, a_day};
    assign act12 = {b_hh, b_hl, b_mh, b_ml, b_sh, b_sl, b_mode, b_day};

    hms_time_counter #(.TICK_DIV(TD), .HOUR_MOD(24)) dut24 (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .up(up), .down(down),
        .sec_lo(a_sl), .sec_hi(a_sh), .min_lo(a_ml), .min_hi(a_mh),
        .hr_lo(a_hl), .hr_hi(a_hh), .mode(a_mode), .day_carry(a_day)
    );

    hms_time_counter #(.TICK_DIV(TD), .HOUR_MOD(12)) dut12 (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .up(up), .down(down),
        .sec_lo(b_sl), .sec_hi(b_sh), .min_lo(b_ml), .min_hi(b_mh),
        .hr_lo(b_hl), .hr_hi(b_hh), .mode(b_mode), .day_carry(b_day)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;

    // Reference: time kept as plain integers, index 0 = 24-hour, 1 = 12-hour.
    int m_h[2], m_m[2], m_s[2], m_pre[2], m_mode[2];
    bit m_day[2];
    int hmod[2] = '{24, 12};

    function automatic logic [26:0] pack(input int h, input int m, input int s, input int md, input bit dy);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 2'(md), dy};
    endfunction

    function automatic string fmt(input logic [26:0] v);
        return $sformatf("%h:%h:%h mode=%0d day=%0b", v[26:19], v[18:11], v[10:3], v[2:1], v[0]);
    endfunction

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %s required %s", name, fmt(act), fmt(exp));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_h[i] = 0; m_m[i] = 0; m_s[i] = 0; m_pre[i] = 0; m_mode[i] = 0; m_day[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit mb, input bit u, input bit d);
        int tot;
        bit tick;
        tick = (m_mode[i] == 0) && (m_pre[i] == TD - 1);
        m_day[i] = 0;
        if (tick) begin
            tot = m_h[i] * 3600 + m_m[i] * 60 + m_s[i] + 1;
            if (tot == hmod[i] * 3600) begin
                m_day[i] = 1;
                tot = 0;
            end
            m_h[i] = tot / 3600;
            m_m[i] = (tot / 60) % 60;
            m_s[i] = tot % 60;
        end
        if (m_mode[i] == 0 && !mb)
            m_pre[i] = tick ? 0 : m_pre[i] + 1;
        else
            m_pre[i] = 0;
        if (m_mode[i] == 1 && u != d)
            m_m[i] = (m_m[i] + (u ? 1 : 59)) % 60;
        if (m_mode[i] == 2 && u != d)
            m_h[i] = (m_h[i] + (u ? 1 : hmod[i] - 1)) % hmod[i];
        if (m_mode[i] == 0 && mb)
            m_s[i] = 0;
        if (mb)
            m_mode[i] = (m_mode[i] + 1) % 3;
    endtask

    task automatic step(input bit mb, input bit u, input bit d);
        mode_btn = mb;
        up = u;
        down = d;
        model_step(0, mb, u, d);
        model_step(1, mb, u, d);
        @(posedge clk);
        #1;
        check("model24", act24, pack(m_h[0], m_m[0], m_s[0], m_mode[0], m_day[0]));
        check("model12", act12, pack(m_h[1], m_m[1], m_s[1], m_mode[1], m_day[1]));
    endtask

    task automatic do_reset();
        mode_btn = 0;
        up = 0;
        down = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        check("reset24", act24, pack(0, 0, 0, 0, 0));
        check("reset12", act12, pack(0, 0, 0, 0, 0));
    endtask

    typedef struct {
        bit mb;
        bit u;
        bit d;
        int h;
        int m;
        int s;
        int md;
        bit dy;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0,  0,  0, 0, 1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1,  0, 59, 0, 1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0,  0,  0, 0, 1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1,  0, 59, 0, 1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1,  0, 59, 0, 1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1,  0, 58, 0, 2, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 23, 58, 0, 2, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0,  0, 58, 0, 2, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 23, 58, 0, 2, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 23, 58, 0, 2, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 23, 58, 0, 0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 23, 58, 0, 0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 23, 58, 0, 0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 23, 58, 0, 0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 23, 58, 1, 0, 1'b0};

        // Reset and first ticks
        do_reset();
        repeat (TD) step(0, 0, 0);
        check("first_tick", act24, pack(0, 0, 1, 0, 0));
        repeat (TD) step(0, 0, 0);
        check("second_tick", act24, pack(0, 0, 2, 0, 0));

        // Vector table through the set states and back into RUN
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].mb, tbl[i].u, tbl[i].d);
            check($sformatf("tbl%0d", i), act24,
                  pack(tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].md, tbl[i].dy));
        end

        // Set 23:59 (11:59 on the 12-hour part), exercise hour wrap, then midnight rollover
        do_reset();
        step(1, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 0, 1);
        check("h12_set11", act12, pack(11, 59, 0, 2, 0));
        step(0, 1, 0);
        check("h12_up_wrap", act12, pack(0, 59, 0, 2, 0));
        step(0, 0, 1);
        check("h12_down_wrap", act12, pack(11, 59, 0, 2, 0));
        check("h24_set23", act24, pack(23, 59, 0, 2, 0));
        step(1, 0, 0);
        repeat (59 * TD) step(0, 0, 0);
        check("pre_midnight24", act24, pack(23, 59, 59, 0, 0));
        check("pre_midnight12", act12, pack(11, 59, 59, 0, 0));
        repeat (TD) step(0, 0, 0);
        check("midnight24", act24, pack(0, 0, 0, 0, 1));
        check("midnight12", act12, pack(0, 0, 0, 0, 1));
        step(0, 0, 0);
        check("day_carry_drop24", act24, pack(0, 0, 0, 0, 0));
        check("day_carry_drop12", act12, pack(0, 0, 0, 0, 0));

        // Simultaneous inputs at minute 07
        do_reset();
        step(1, 0, 0);
        repeat (7) step(0, 1, 0);
        check("min07", act24, pack(0, 7, 0, 1, 0));
        step(0, 1, 1);
        check("up_down_same", act24, pack(0, 7, 0, 1, 0));
        step(1, 1, 0);
        check("mode_with_up", act24, pack(0, 8, 0, 2, 0));

        // Reset asserted mid-cycle while in SET_HOUR at 15:42:00
        do_reset();
        step(1, 0, 0);
        repeat (42) step(0, 1, 0);
        step(1, 0, 0);
        repeat (15) step(0, 1, 0);
        check("set_15_42", act24, pack(15, 42, 0, 2, 0));
        #2;
        reset = 1;
        mode_btn = 0;
        up = 0;
        down = 0;
        model_reset();
        #1;
        check("async_reset24", act24, pack(0, 0, 0, 0, 0));
        check("async_reset12", act12, pack(0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        repeat (TD - 1) step(0, 0, 0);
        check("post_reset_no_tick", act24, pack(0, 0, 0, 0, 0));
        step(0, 0, 0);
        check("post_reset_tick", act24, pack(0, 0, 1, 0, 0));

        // Randomized stimulus against the model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
